multicycle_ctrl_fsm: RTL and testbench
======================================

MULTICYCLE_CTRL_FSM -- requirements
Module: multicycle_ctrl_fsm

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset. The clock port SHALL be named clk and the reset port SHALL be named reset.
REQ-002 Ports SHALL be exactly as listed below.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- op  in  7  instruction opcode [6:0]
- funct3  in  3  instruction funct3
- funct7b5  in  1  instruction bit 30
- zero  in  1  ALU zero flag, current cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut
- MemWrite  out  1  data memory write enable
- IRWrite  out  1  instruction register enable
- ResultSrc  out  2  result select: 00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  2  operand A select: 00=PC, 01=OldPC, 10=RD1
- ALUSrcB  out  2  operand B select: 00=RD2, 01=ImmExt, 10=const 4
- RegWrite  out  1  register file write enable
- ImmSrc  out  2  immediate format select
- ALUControl  out  4  ALU operation
- illegal_op  out  1  unsupported opcode seen in DECODE
- state_o  out  4  current state, for debug

Function
REQ-003 The block SHALL be a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, JAL=10. Codes 11-15 SHALL transition to FETCH.
REQ-004 Transitions SHALL be as follows.
- FETCH->DECODE.
- DECODE by op: 0000011 or 0100011 ->MEMADR; 0110011 ->EXECUTER; 0010011 ->EXECUTEI; 1100011 ->BRANCH; 1101111 ->JAL; any other op ->FETCH.
- MEMADR: op=0000011 ->MEMREAD, else ->MEMWRITE.
- MEMREAD->MEMWB.
- MEMWB, MEMWRITE and BRANCH ->FETCH.
- EXECUTER, EXECUTEI and JAL ->ALUWB.
- ALUWB->FETCH.
REQ-005 Outputs SHALL be decoded from state only, except PCWrite, ImmSrc, ALUControl and illegal_op. Any field not listed for a state SHALL be 0.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, PCUpdate=1, ALUOp=00.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
- MEMREAD: AdrSrc=1, ResultSrc=00.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: AdrSrc=1, MemWrite=1.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: ResultSrc=00, RegWrite=1.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
REQ-006 PCWrite SHALL equal PCUpdate | (Branch & (zero ^ funct3[0])), evaluated combinationally in the same cycle. This makes funct3=000 taken when zero=1 (beq) and funct3=001 taken when zero=0 (bne).
REQ-007 ImmSrc SHALL be decoded combinationally from op: 0000011/0010011 ->00; 0100011 ->01; 1100011 ->10; 1101111 ->11; any other op ->00.
REQ-008 ALUControl SHALL be derived from the internal 2-bit ALUOp.
- ALUOp=00 ->0000 (add).
- ALUOp=01 ->0001 (sub).
- Otherwise, by funct3:
  - 000: 0001 if funct7b5&op[5], else 0000.
  - 001: 0011.
  - 010: 0100.
  - 011: 0101.
  - 100: 0110.
  - 101: 0111 if funct7b5, else 1000.
  - 110: 1001.
  - 111: 1010.
REQ-009 illegal_op SHALL be 1 only in DECODE when op is unsupported, and only for that one cycle. No write enable SHALL assert for that instruction.
REQ-010 Instruction latency SHALL be: lw 5 cycles; sw 4; R-type 4; I-type ALU 4; branch 3; jal 4.
REQ-011 No two of MemWrite, RegWrite and IRWrite SHALL be 1 in the same cycle.

Reset
REQ-012 When reset=1 at a rising edge, the state SHALL become FETCH on that edge, regardless of the current state.
REQ-013 While reset=1, PCWrite, MemWrite, IRWrite and RegWrite SHALL be forced to 0. All other outputs SHALL follow the FETCH decode.
REQ-014 If reset asserts mid-instruction (e.g. in MEMWRITE), that instruction SHALL be abandoned with no further write enables. The first cycle after reset deasserts SHALL be FETCH with IRWrite=1 and PCWrite=1.

Verification
REQ-015 The bench SHALL cover the following directed scenarios.
- lw: op=0000011 from reset -> state_o sequence 0,1,2,3,4,0. RegWrite=1 only in state 4, with ResultSrc=01.
- R-type sub: op=0110011, funct3=000, funct7b5=1 -> ALUControl=0001 in EXECUTER. Same with op=0010011 -> ALUControl=0000 (addi).
- Branches:
  - op=1100011, funct3=000, zero=1 in BRANCH -> PCWrite=1.
  - funct3=001, zero=1 -> PCWrite=0.
  - In both cases ALUControl=0001 and 3 cycles total.
- jal: op=1101111 -> states 0,1,10,8,0. PCWrite=1 in JAL, RegWrite=1 in ALUWB, ImmSrc=11 throughout.
- Illegal op: op=1111111 -> illegal_op=1 for exactly one cycle in DECODE, then FETCH. No MemWrite or RegWrite.
- Reset in MEMWRITE: assert reset for 1 cycle -> MemWrite=0 that cycle, state_o=0 next cycle, and no write enables while reset=1.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// Control FSM for a multicycle RV32I subset datapath (lw, sw, R-type, I-type ALU, beq/bne, jal).
// State-decoded controls are registered from the next state; PCWrite, ImmSrc, ALUControl are combinational.
module multicycle_ctrl_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic [1:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9,
    StJal      = 4'd10
  } state_e;

  typedef struct packed {
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       pc_update;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic ctrl_t decode(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      StFetch: begin
        c.ir_write   = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
        c.pc_update  = 1'b1;
      end
      StDecode: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
      end
      StMemAdr: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
      end
      StMemRead: c.adr_src = 1'b1;
      StMemWb: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
      end
      StMemWrite: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      StExecR: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b10;
      end
      StExecI: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b10;
      end
      StAluWb: c.reg_write = 1'b1;
      StBranch: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b01;
        c.branch    = 1'b1;
      end
      StJal: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        c.pc_update = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_e state_q, state_d;
  ctrl_t  ctrl_q, ctrl;
  logic   op_legal;

  always_comb begin
    op_legal = 1'b0;
    case (op)
      OpLoad, OpStore, OpRType, OpIType, OpBranch, OpJal: op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        case (op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = StExecR;
          OpIType:         state_d = StExecI;
          OpBranch:        state_d = StBranch;
          OpJal:           state_d = StJal;
          default:         state_d = StFetch;
        endcase
      end
      StMemAdr:                 state_d = (op == OpLoad) ? StMemRead : StMemWrite;
      StMemRead:                state_d = StMemWb;
      StExecR, StExecI, StJal:  state_d = StAluWb;
      default:                  state_d = StFetch;
    endcase
  end

  // Controls are registered from the next state so they are valid in the cycle the state is.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      ctrl_q  <= decode(StFetch);
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode(state_d);
    end
  end

  always_comb begin
    ctrl = ctrl_q;
    if (reset) begin
      ctrl = decode(StFetch);
    end

    // beq takes on zero, bne on not-zero: funct3[0] inverts the sense.
    PCWrite   = ~reset & (ctrl.pc_update | (ctrl.branch & (zero ^ funct3[0])));
    AdrSrc    = ctrl.adr_src;
    MemWrite  = ctrl.mem_write & ~reset;
    IRWrite   = ctrl.ir_write & ~reset;
    RegWrite  = ctrl.reg_write & ~reset;
    ResultSrc = ctrl.result_src;
    ALUSrcA   = ctrl.alu_src_a;
    ALUSrcB   = ctrl.alu_src_b;

    case (op)
      OpStore:  ImmSrc = 2'b01;
      OpBranch: ImmSrc = 2'b10;
      OpJal:    ImmSrc = 2'b11;
      default:  ImmSrc = 2'b00;
    endcase

    case (ctrl.alu_op)
      2'b00: ALUControl = 4'b0000;
      2'b01: ALUControl = 4'b0001;
      default: begin
        case (funct3)
          3'b000:  ALUControl = (funct7b5 & op[5]) ? 4'b0001 : 4'b0000;
          3'b001:  ALUControl = 4'b0011;
          3'b010:  ALUControl = 4'b0100;
          3'b011:  ALUControl = 4'b0101;
          3'b100:  ALUControl = 4'b0110;
          3'b101:  ALUControl = funct7b5 ? 4'b0111 : 4'b1000;
          3'b110:  ALUControl = 4'b1001;
          default: ALUControl = 4'b1010;
        endcase
      end
    endcase

    illegal_op = ~reset & (state_q == StDecode) & ~op_legal;
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: directed instructions then random ones, each cycle checked against
// a per-instruction state-sequence model and a per-state control table.
module tb_multicycle_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [3:0] ALUControl, state_o;

  multicycle_ctrl_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .RegWrite   (RegWrite),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .illegal_op (illegal_op),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5;
  localparam int EXECUTER = 6, EXECUTEI = 7, ALUWB = 8, BRANCH = 9, JAL = 10;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RTYPE = 7'b0110011;
  localparam logic [6:0] ITYPE = 7'b0010011, BR = 7'b1100011, JALOP = 7'b1101111;

  int vectors = 0;
  int miscompares = 0;

  // {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, RegWrite, ImmSrc,
  //  ALUControl, illegal_op}
  logic [17:0] obs_vec;
  assign obs_vec = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, RegWrite,
                    ImmSrc, ALUControl, illegal_op};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit supported(input logic [6:0] o);
    return (o == LW) || (o == SW) || (o == RTYPE) || (o == ITYPE) || (o == BR) || (o == JALOP);
  endfunction

  // Expected controls for model state s with the inputs currently applied.
  function automatic logic [17:0] exp_outs(input int s, input bit rst);
    logic       pcw, adr, mw, irw, rw, ill;
    logic [1:0] rs, sa, sb, imm;
    logic [3:0] aluc;
    int         eff;
    int         alu_kind;  // 0 add, 1 sub, 2 by funct3
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0;
    rs = 0; sa = 0; sb = 0; alu_kind = 0;
    eff = rst ? FETCH : s;
    case (eff)
      FETCH:    begin irw = 1; sb = 2; rs = 2; pcw = 1; end
      DECODE:   begin sa = 1; sb = 1; end
      MEMADR:   begin sa = 2; sb = 1; end
      MEMREAD:  adr = 1;
      MEMWB:    begin rs = 1; rw = 1; end
      MEMWRITE: begin adr = 1; mw = 1; end
      EXECUTER: begin sa = 2; alu_kind = 2; end
      EXECUTEI: begin sa = 2; sb = 1; alu_kind = 2; end
      ALUWB:    rw = 1;
      BRANCH:   begin sa = 2; alu_kind = 1; pcw = funct3[0] ? !zero : zero; end
      JAL:      begin sa = 1; sb = 2; pcw = 1; end
      default:  ;
    endcase
    if (rst) begin
      pcw = 0; irw = 0; mw = 0; rw = 0;
    end
    if (op == SW) imm = 2'd1;
    else if (op == BR) imm = 2'd2;
    else if (op == JALOP) imm = 2'd3;
    else imm = 2'd0;
    if (alu_kind == 0) aluc = 4'd0;
    else if (alu_kind == 1) aluc = 4'd1;
    else begin
      case (funct3)
        3'd0: aluc = (funct7b5 && op[5]) ? 4'd1 : 4'd0;
        3'd1: aluc = 4'd3;
        3'd2: aluc = 4'd4;
        3'd3: aluc = 4'd5;
        3'd4: aluc = 4'd6;
        3'd5: aluc = funct7b5 ? 4'd7 : 4'd8;
        3'd6: aluc = 4'd9;
        default: aluc = 4'd10;
      endcase
    end
    ill = !rst && (s == DECODE) && !supported(op);
    return {pcw, adr, mw, irw, rs, sa, sb, rw, imm, aluc, ill};
  endfunction

  // Runs one instruction starting in its FETCH cycle. zsel: 0/1 fixed zero, 2 random.
  // rst_at >= 0 asserts reset during that step of the instruction and abandons it.
  task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input int zsel, input int rst_at);
    int  seq[$];
    bit  aborted;
    seq = {FETCH, DECODE};
    if (o == LW) seq = {seq, MEMADR, MEMREAD, MEMWB};
    else if (o == SW) seq = {seq, MEMADR, MEMWRITE};
    else if (o == RTYPE) seq = {seq, EXECUTER, ALUWB};
    else if (o == ITYPE) seq = {seq, EXECUTEI, ALUWB};
    else if (o == BR) seq = {seq, BRANCH};
    else if (o == JALOP) seq = {seq, JAL, ALUWB};
    aborted = 0;
    foreach (seq[i]) begin
      #1;
      op = o; funct3 = f3; funct7b5 = f7;
      zero = (zsel == 2) ? 1'($urandom_range(0, 1)) : (zsel == 1);
      if (i == rst_at) reset = 1'b1;
      #2;
      if (reset) begin
        chk({name, "/rst_ctrl"}, 32'(obs_vec), 32'(exp_outs(seq[i], 1)));
      end else begin
        chk({name, "/state"}, 32'(state_o), 32'(seq[i]));
        chk({name, "/ctrl"}, 32'(obs_vec), 32'(exp_outs(seq[i], 0)));
      end
      chk({name, "/we_excl"}, 32'($countones({MemWrite, RegWrite, IRWrite}) <= 1), 32'd1);
      @(posedge clk);
      if (reset) begin
        aborted = 1;
        break;
      end
    end
    if (aborted) begin
      #1 reset = 1'b0;
    end
  endtask

  initial begin
    logic [6:0] ops [6];
    logic [6:0] o;
    ops[0] = LW; ops[1] = SW; ops[2] = RTYPE; ops[3] = ITYPE; ops[4] = BR; ops[5] = JALOP;

    // Reset state: FETCH decode with write enables held off.
    @(posedge clk);
    #3;
    chk("reset/state", 32'(state_o), 32'(FETCH));
    chk("reset/ctrl", 32'(obs_vec), 32'(exp_outs(FETCH, 1)));
    @(posedge clk);
    #1 reset = 1'b0;

    run_instr("lw", LW, 3'd2, 1'b0, 2, -1);
    run_instr("sub", RTYPE, 3'd0, 1'b1, 2, -1);
    run_instr("addi", ITYPE, 3'd0, 1'b1, 2, -1);
    run_instr("beq_taken", BR, 3'd0, 1'b0, 1, -1);
    run_instr("bne_not_taken", BR, 3'd1, 1'b0, 1, -1);
    run_instr("bne_taken", BR, 3'd1, 1'b0, 0, -1);
    run_instr("jal", JALOP, 3'd0, 1'b0, 2, -1);
    run_instr("illegal", 7'b1111111, 3'd0, 1'b0, 2, -1);
    run_instr("sw", SW, 3'd2, 1'b0, 2, -1);
    run_instr("sw_reset", SW, 3'd2, 1'b0, 2, 3);

    // After the abandoned store the next cycle must be a clean FETCH.
    run_instr("post_reset_lw", LW, 3'd2, 1'b0, 2, -1);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 6) == 0) o = 7'($urandom);
      else o = ops[$urandom_range(0, 5)];
      run_instr("rand", o, 3'($urandom), 1'($urandom),
                2, ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
